// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arbiter
// Description : Round-robin writeback arbiter between EXU and LSU that feeds
//               the single GPR write port, emits a retire pulse with its PC,
//               counts retired instructions and can freeze the GPR file for a
//               difftest snapshot (RUN/HOLD).
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // EXU writeback request
  input  logic            exu_valid_i,
  output logic            exu_ready_o,
  input  logic [AW-1:0]   exu_rd_i,
  input  logic [XLEN-1:0] exu_data_i,
  input  logic [XLEN-1:0] exu_pc_i,
  // LSU writeback request
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [AW-1:0]   lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic [XLEN-1:0] lsu_pc_i,
  // GPR write port
  output logic            rf_wen_o,
  output logic [AW-1:0]   rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  // retire report
  output logic            commit_valid_o,
  output logic [XLEN-1:0] commit_pc_o,
  // difftest snapshot handshake
  input  logic            dbg_hold_i,
  output logic            dbg_hold_ack_o,
  output logic [63:0]     instret_o
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e          state_q;
  logic            last_lsu_q;      // 1: LSU won the most recent grant
  logic            commit_valid_q;
  logic            rf_wen_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [XLEN-1:0] commit_pc_q;
  logic [63:0]     instret_q;

  logic            w_run;
  logic            w_exu_fire;
  logic            w_lsu_fire;
  logic            w_fire;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [XLEN-1:0] w_sel_pc;

  // Grant logic: only the registered state gates acceptance, so dbg_hold never
  // reaches ready combinationally; reset also blocks acceptance immediately.
  always_comb begin
    w_run       = (state_q == ST_RUN) && !rst_i;
    exu_ready_o = w_run && exu_valid_i && (!lsu_valid_i || last_lsu_q);
    lsu_ready_o = w_run && lsu_valid_i && (!exu_valid_i || !last_lsu_q);
    w_exu_fire  = exu_valid_i && exu_ready_o;
    w_lsu_fire  = lsu_valid_i && lsu_ready_o;
    w_fire      = w_exu_fire || w_lsu_fire;
    w_sel_rd    = w_lsu_fire ? lsu_rd_i   : exu_rd_i;
    w_sel_data  = w_lsu_fire ? lsu_data_i : exu_data_i;
    w_sel_pc    = w_lsu_fire ? lsu_pc_i   : exu_pc_i;
  end

  // RUN/HOLD state, arbitration pointer and registered writeback outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_RUN;
      last_lsu_q     <= 1'b1;
      commit_valid_q <= 1'b0;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_pc_q    <= '0;
      instret_q      <= '0;
    end else begin
      state_q        <= dbg_hold_i ? ST_HOLD : ST_RUN;
      commit_valid_q <= w_fire;
      // x0 is hardwired to zero: it retires but is never written.
      rf_wen_q       <= w_fire && (w_sel_rd != '0);
      if (w_fire) begin
        last_lsu_q  <= w_lsu_fire;
        rf_waddr_q  <= w_sel_rd;
        rf_wdata_q  <= w_sel_data;
        commit_pc_q <= w_sel_pc;
        instret_q   <= instret_q + 64'd1;
      end
    end
  end

  // Snapshot is safe once frozen and the last accepted write has landed.
  assign dbg_hold_ack_o = (state_q == ST_HOLD) && !commit_valid_q;

  assign rf_wen_o       = rf_wen_q;
  assign rf_waddr_o     = rf_waddr_q;
  assign rf_wdata_o     = rf_wdata_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_pc_o    = commit_pc_q;
  assign instret_o      = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpr_wb_arbiter
// Description : Scoreboard bench for gpr_wb_arbiter: a transaction-level
//               model predicts grants and pushes expected retirements into a
//               queue; a monitor pops and compares what the DUT commits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_wb_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev = 1'b0, lv = 1'b0, hold = 1'b0;
  logic [4:0]  erd = '0, lrd = '0;
  logic [63:0] edata = '0, epc = '0, ldata = '0, lpc = '0;
  logic        exu_ready, lsu_ready, rf_wen, commit_valid, hold_ack;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata, commit_pc, instret;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  exp_t        q[$];
  exp_t        pend;
  logic        pend_v = 1'b0, pend_lsu = 1'b0;
  logic        ptr_lsu = 1'b1;   // who won the last grant
  logic        hold_m = 1'b0;    // frozen as seen by the DUT this cycle
  logic        hold_s = 1'b0;
  logic        acc_e = 1'b0, acc_l = 1'b0;
  logic [63:0] exp_instret = '0;
  logic [4:0]  exp_waddr = '0;
  logic [63:0] exp_wdata = '0;

  gpr_wb_arbiter #(.XLEN(64), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .exu_valid_i(ev), .exu_ready_o(exu_ready), .exu_rd_i(erd), .exu_data_i(edata), .exu_pc_i(epc),
    .lsu_valid_i(lv), .lsu_ready_o(lsu_ready), .lsu_rd_i(lrd), .lsu_data_i(ldata), .lsu_pc_i(lpc),
    .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .commit_valid_o(commit_valid), .commit_pc_o(commit_pc),
    .dbg_hold_i(hold), .dbg_hold_ack_o(hold_ack), .instret_o(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend_v = 1'b0; ptr_lsu = 1'b1; hold_m = 1'b0;
    acc_e = 1'b0; acc_l = 1'b0;
    exp_instret = '0; exp_waddr = '0; exp_wdata = '0;
  endtask

  // Advance one clock; the model applies what the DUT accepted at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    acc_e = 1'b0; acc_l = 1'b0;
    if (!rst) begin
      if (pend_v) begin
        q.push_back(pend);
        ptr_lsu = pend_lsu;
        acc_e = !pend_lsu;
        acc_l = pend_lsu;
      end
      hold_m = hold_s;
    end
    pend_v = 1'b0;
  endtask

  function automatic logic [4:0] rnd_rd();
    if ($urandom_range(0, 3) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  // Stimulus-side model: who should be granted this cycle.
  always @(negedge clk) begin
    int win;  // 0 none, 1 EXU, 2 LSU
    hold_s = hold;
    win = 0;
    if (!rst && !hold_m) begin
      if (ev && lv)  win = ptr_lsu ? 1 : 2;  // alternate on contention
      else if (ev)   win = 1;
      else if (lv)   win = 2;
    end
    chk("exu_ready", {63'd0, exu_ready}, {63'd0, win == 1});
    chk("lsu_ready", {63'd0, lsu_ready}, {63'd0, win == 2});
    pend_v   = (win != 0);
    pend_lsu = (win == 2);
    if (win == 2) pend = '{rd: lrd, data: ldata, pc: lpc};
    else          pend = '{rd: erd, data: edata, pc: epc};
  end

  // Monitor: retire whatever the DUT presents against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    logic exp_cv;
    exp_cv = (q.size() > 0);
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, exp_cv});
    if (exp_cv) begin
      e = q.pop_front();
      exp_instret = exp_instret + 64'd1;
      exp_waddr = e.rd;
      exp_wdata = e.data;
      chk("commit_pc", commit_pc, e.pc);
      chk("rf_wen", {63'd0, rf_wen}, {63'd0, e.rd != 5'd0});
    end else begin
      chk("rf_wen_idle", {63'd0, rf_wen}, 64'd0);
    end
    chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, exp_waddr});
    chk("rf_wdata", rf_wdata, exp_wdata);
    chk("instret", instret, exp_instret);
    chk("hold_ack", {63'd0, hold_ack}, {63'd0, hold_m && !exp_cv && !rst});
  end

  task automatic rand_inputs();
    if (!(ev && !acc_e)) begin
      ev = ($urandom_range(0, 2) != 0);
      erd = rnd_rd(); edata = {$urandom, $urandom}; epc = {32'h0, $urandom & 32'hFFFF_FFFC};
    end
    if (!(lv && !acc_l)) begin
      lv = ($urandom_range(0, 2) != 0);
      lrd = rnd_rd(); ldata = {$urandom, $urandom}; lpc = {32'h0, $urandom & 32'hFFFF_FFFC};
    end
    if ($urandom_range(0, 15) == 0) hold = !hold;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // contention right after reset: EXU, LSU, EXU, LSU
    ev = 1'b1; erd = 5'd1; edata = 64'h11; epc = 64'h100;
    lv = 1'b1; lrd = 5'd2; ldata = 64'h22; lpc = 64'h200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("tie_grant_exu", {63'd0, exu_ready}, {63'd0, (i % 2) == 0});
      tick();
      if (acc_e) begin erd = 5'(3 + i); edata = 64'(i + 64'h30); epc = 64'(64'h300 + i * 4); end
      if (acc_l) begin lrd = 5'(8 + i); ldata = 64'(i + 64'h40); lpc = 64'(64'h400 + i * 4); end
    end
    ev = 1'b0; lv = 1'b0;
    chk("tie_instret", instret, 64'd4);

    // retire to x0: committed but not written
    ev = 1'b1; erd = 5'd0; edata = 64'hDEAD; epc = 64'h8000_0000;
    tick(); ev = 1'b0;
    chk("x0_commit", {63'd0, commit_valid}, 64'd1);
    chk("x0_wen", {63'd0, rf_wen}, 64'd0);
    chk("x0_instret", instret, 64'd5);

    // ordinary LSU load writeback
    lv = 1'b1; lrd = 5'd5; ldata = 64'h1234; lpc = 64'h8000_0010;
    tick(); lv = 1'b0;
    chk("wr_wen", {63'd0, rf_wen}, 64'd1);
    chk("wr_waddr", {59'd0, rf_waddr}, 64'd5);
    chk("wr_wdata", rf_wdata, 64'h1234);
    chk("wr_pc", commit_pc, 64'h8000_0010);

    // hold rises with a transfer accepted in the same cycle
    tick();
    ev = 1'b1; erd = 5'd3; edata = 64'hABCD; epc = 64'h8000_0020; hold = 1'b1;
    tick();
    ev = 1'b1; erd = 5'd4; edata = 64'h5555; epc = 64'h8000_0024; lv = 1'b1;
    chk("hold_commit", {63'd0, commit_valid}, 64'd1);
    chk("hold_ack_early", {63'd0, hold_ack}, 64'd0);
    chk("hold_rdy", {62'd0, exu_ready, lsu_ready}, 64'd0);
    tick();
    chk("hold_ack", {63'd0, hold_ack}, 64'd1);
    hold = 1'b0;
    tick();
    chk("release_rdy", {62'd0, exu_ready, lsu_ready}, 64'd1);  // LSU wins: EXU went last
    tick(); ev = 1'b0; lv = acc_l ? 1'b0 : lv;
    tick(); lv = 1'b0;
    tick();

    // asynchronous reset while a transfer is being accepted
    ev = 1'b1; erd = 5'd9; edata = 64'h9999; epc = 64'h8000_0040;
    #2;
    chk("rst_pre_rdy", {63'd0, exu_ready}, 64'd1);
    rst = 1'b1; model_reset();
    #1;
    chk("rst_cv", {63'd0, commit_valid}, 64'd0);
    chk("rst_wen", {63'd0, rf_wen}, 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_pc", commit_pc, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_rdy", {62'd0, exu_ready, lsu_ready}, 64'd0);
    tick(); ev = 1'b0;
    tick(); rst = 1'b0;
    tick();
    chk("rst_no_commit", {63'd0, commit_valid}, 64'd0);
    chk("rst_instret2", instret, 64'd0);

    // instret wraps modulo 2^64
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    ev = 1'b1; erd = 5'd7; edata = 64'h77; epc = 64'h8000_0050;
    tick(); ev = 1'b0;
    chk("wrap_instret", instret, 64'd0);

    // randomized traffic with hold toggling
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    ev = 1'b0; lv = 1'b0; hold = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 64, data and PC width.
REQ-002 Parameter: AW, 5, GPR index width.
REQ-003 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: exu_valid / exu_ready  in / out  1 / 1  EXU writeback handshake.
REQ-006 Port: exu_rd / exu_data / exu_pc  in  AW / XLEN / XLEN  EXU destination, result, instruction PC.
REQ-007 Port: lsu_valid / lsu_ready  in / out  1 / 1  LSU writeback handshake.
REQ-008 Port: lsu_rd / lsu_data / lsu_pc  in  AW / XLEN / XLEN  LSU destination, load data, instruction PC.
REQ-009 Port: rf_wen / rf_waddr / rf_wdata  out  1 / AW / XLEN  single GPR write port.
REQ-010 Port: commit_valid / commit_pc  out  1 / XLEN  one-cycle retire pulse and PC for difftest.
REQ-011 Port: dbg_hold  in  1  difftest requests a frozen GPR snapshot.
REQ-012 Port: dbg_hold_ack  out  1  GPR state is stable; snapshot may be read.
REQ-013 Port: instret  out  64  retired-instruction count.

Function
REQ-014 The block SHALL use FSM states RUN and HOLD.
REQ-015 RUN -> HOLD SHALL occur on the edge where dbg_hold=1; HOLD -> RUN SHALL occur on the edge where dbg_hold=0.
REQ-016 In HOLD, exu_ready and lsu_ready SHALL be 0.
REQ-017 In RUN, both ready outputs SHALL be combinational in valid inputs and the priority pointer.
REQ-018 In RUN, a lone valid requester SHALL get ready=1.
REQ-019 When both requesters are valid in RUN, ready SHALL go to the requester that did not win the last grant (round-robin).
REQ-020 The last-winner pointer SHALL update only on an accepted transfer (valid && ready).
REQ-021 At most one transfer SHALL be accepted per cycle.
REQ-022 Ready SHALL NOT depend on dbg_hold combinationally; it SHALL depend only on the registered FSM state.
REQ-023 An accepted transfer SHALL appear on the outputs exactly one cycle later as registered values: commit_valid=1, commit_pc=pc, rf_waddr=rd, rf_wdata=data.
REQ-024 In that output cycle, rf_wen SHALL be 1 if rd!=0.
REQ-025 If rd==0, rf_wen SHALL be 0 while commit_valid is still 1; x0 is never written.
REQ-026 With no transfer accepted in the prior cycle, commit_valid and rf_wen SHALL be 0 and rf_waddr/rf_wdata SHALL hold their last values.
REQ-027 instret SHALL increment by 1 in each cycle commit_valid=1, wrapping modulo 2^64.
REQ-028 dbg_hold_ack SHALL be 1 iff state==HOLD and commit_valid==0 (no write in flight).
REQ-029 With dbg_hold asserted, dbg_hold_ack SHALL rise no later than 2 cycles after dbg_hold rises.
REQ-030 A transfer accepted in the cycle dbg_hold rises SHALL still commit in the next cycle, before dbg_hold_ack rises.
REQ-031 Requesters SHALL hold their payload stable while valid && !ready; the block does not buffer unaccepted requests.

Reset
REQ-032 On reset assertion, all state and outputs SHALL clear immediately, without waiting for a clock edge: state=RUN, pointer="last winner LSU" (EXU wins first tie), rf_wen=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_pc=0, instret=0, dbg_hold_ack=0.
REQ-033 While reset=1, exu_ready and lsu_ready SHALL be 0.
REQ-034 A transfer in flight when reset asserts SHALL be discarded: no write and no commit.

Verification
REQ-035 Tie arbitration: after reset, hold exu_valid=lsu_valid=1 for 4 cycles -> grants EXU, LSU, EXU, LSU; instret=4 one cycle after the last grant.
REQ-036 x0 write: EXU rd=0, data=0xDEAD -> next cycle commit_valid=1, rf_wen=0, instret increments.
REQ-037 Normal write: LSU rd=5, data=0x1234, pc=0x80000010 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, commit_pc=0x80000010.
REQ-038 Hold with transfer in flight: dbg_hold rises in the same cycle as an accepted EXU transfer -> commit in cycle+1; readies 0 from cycle+1; dbg_hold_ack=1 at cycle+2; dbg_hold release -> readies return the next cycle.
REQ-039 Async reset mid-transfer: assert reset between clock edges while a transfer is accepted -> outputs 0 immediately, no commit follows, instret=0.
REQ-040 instret wrap: force instret=2^64-1, then commit once -> instret=0.
